// File: rtl/cla_pkg.sv
// Shared definitions for the serial CLA subtractor.
//   SLICE_W : width of one carry-lookahead slice
//   state_e : control FSM states
//   idx_w() : width of the slice index counter for n slices (never below 1)
package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
//   x, y : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // All carries are flat sum-of-products of g/p/ci; no ripple inside the slice.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/cla_serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), computed as a + ~b + ~bin
// through one shared 4-bit CLA slice, least-significant slice first.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, bin)
//   out_valid/out_ready  : result handshake (diff, bout, ovf)
// Optional macro CLA_SUB_OVF_EN enables signed-overflow detection; otherwise ovf is 0.
module cla_serial_sub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N   = WIDTH / SLICE_W;
  localparam int unsigned K_W = idx_w(N);
  localparam logic [K_W-1:0] KLast = K_W'(N - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("cla_serial_sub: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;     // inverted subtrahend
  logic             carry_q;
  logic [K_W-1:0]   k_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             out_valid_q;

  int unsigned      k_int;
  logic [3:0]       sum;
  logic             co;
  logic             last;

  assign k_int = 32'(k_q);
  assign last  = (k_q == KLast);

  cla4_slice u_slice (
    .x  (a_q[k_int*SLICE_W +: SLICE_W]),
    .y  (nb_q[k_int*SLICE_W +: SLICE_W]),
    .ci (carry_q),
    .s  (sum),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            nb_q    <= ~b;
            carry_q <= ~bin;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          diff_q[k_int*SLICE_W +: SLICE_W] <= sum;
          carry_q <= co;
          if (last) begin
            k_q         <= '0;
            bout_q      <= ~co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CLA_SUB_OVF_EN
  logic a_sign_q;
  logic b_sign_q;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_sign_q <= a[WIDTH-1];
        b_sign_q <= b[WIDTH-1];
      end
      // sum[3] on the last slice is the result sign bit.
      if (state_q == RUN && last) begin
        ovf_q <= (a_sign_q != b_sign_q) && (sum[3] != a_sign_q);
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_cla_serial_sub.sv
// Directed self-checking bench for cla_serial_sub at WIDTH=16.
module tb_cla_serial_sub;

  localparam int unsigned WIDTH = 16;

`ifdef CLA_SUB_OVF_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int checks;
  int failures;

  cla_serial_sub #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, then presents operands for exactly one accept edge.
  task automatic start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges after the accept until out_valid; 0xFF on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) cyc = 32'hFF;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid_low", 32'(out_valid), 32'd0);
    chk("hs_in_ready_high", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic bi, input logic [WIDTH-1:0] de, input logic be,
                        input logic oe);
    int cyc;
    start(av, bv, bi);
    wait_done(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    chk({tag, "_diff"}, 32'(diff), 32'(de));
    chk({tag, "_bout"}, 32'(bout), 32'(be));
    chk({tag, "_ovf"}, 32'(ovf), 32'(oe));
    handshake();
  endtask

  initial begin
    int cyc;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;  // must be ignored while in reset
    out_ready = 1'b0;
    a         = 16'hAAAA;
    b         = 16'h5555;
    bin       = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, OvfExp);

    // Borrow in, with out_ready pulsed during RUN (must have no effect).
    start(16'h0005, 16'h0005, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("early_ready_no_valid", 32'(out_valid), 32'd0);
    wait_done(cyc);
    chk("bin_latency", 32'(cyc), 32'd2);
    chk("bin_diff", 32'(diff), 32'hFFFF);
    chk("bin_bout", 32'(bout), 32'd1);
    chk("bin_ovf", 32'(ovf), 32'd0);
    handshake();

    // Backpressure: hold DONE with new operands offered.
    start(16'h0100, 16'h0001, 1'b0);
    wait_done(cyc);
    chk("bp_latency", 32'(cyc), 32'd4);
    a        = 16'h0F0F;
    b        = 16'h0101;
    bin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_diff", 32'(diff), 32'h00FF);
      chk("bp_bout", 32'(bout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    handshake();
    @(negedge clk);  // in_valid still high: accepted on this edge
    in_valid = 1'b0;
    wait_done(cyc);
    chk("bp_next_latency", 32'(cyc), 32'd4);
    chk("bp_next_diff", 32'(diff), 32'h0E0E);
    chk("bp_next_bout", 32'(bout), 32'd0);
    handshake();

    // Reset mid-run at k=2.
    start(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_serial_sub.md
# cla_serial_sub

Multi-cycle two's-complement subtractor computing `diff = a - b - bin` over a WIDTH-bit operand, one 4-bit carry-lookahead slice per clock, least-significant slice first. It is the subtract-direction companion to the team's 4-bit CLA adder. Subtraction is done as `a + ~b + ~bin` through a registered 4-bit CLA slice, which trades latency for area on wide datapaths. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4. Any other value is an elaboration error.
- `clk` input, 1: single clock. All state updates on the rising edge.
- `rst_n` input, 1: reset, synchronous and active-low.
- `in_valid` input, 1: operand bundle valid.
- `in_ready` output, 1: block can accept operands.
- `a` input, WIDTH: minuend.
- `b` input, WIDTH: subtrahend.
- `bin` input, 1: borrow in.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts the result.
- `diff` output, WIDTH: `a - b - bin`, modulo 2^WIDTH.
- `bout` output, 1: borrow out. 1 when the unsigned value of `a` is less than `b + bin`.
- `ovf` output, 1: signed overflow (see Configuration).

## Operation
- N = WIDTH/4 slices.
- States:
  - IDLE: `in_ready=1`. Accept on `in_valid && in_ready`.
    - Latch `a` and `~b`.
    - Set carry register to `~bin`.
    - Set slice index k to 0.
    - Go to RUN.
  - RUN: each cycle, feed slice k of `a`, slice k of `~b`, and the carry register into the CLA slice.
    - Write the 4-bit sum into `diff[4k+3:4k]`.
    - Carry register takes the slice carry-out.
    - k increments. At k = N-1, go to DONE.
  - DONE: `out_valid=1`. `diff`, `bout` and `ovf` hold stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- Result rules:
  - `bout = ~final_carry`.
  - `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, registered on entry to DONE.
- Input handshake:
  - `in_ready = rst_n && (state == IDLE)`.
  - Operands are captured only on the accept edge. Input changes afterwards have no effect.
  - No new operation is accepted while in RUN or DONE.
- Output handshake: `out_valid` is never deasserted without `out_ready` (AXI-style hold).
- Reset values: state IDLE, `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`, carry register 0, k=0. `in_ready` reads 0 while `rst_n` is low.
- Reset mid-operation: `rst_n` low on any edge in RUN or DONE discards the in-flight operation. The block is in IDLE after that edge, with no partial result exposed.
- Boundary conditions:
  - `in_valid` asserted in the same cycle as reset release is not accepted. `in_ready` is 0 in that cycle.
  - `out_ready` high before DONE has no effect.
  - WIDTH=4 means N=1: RUN lasts one cycle.

## Timing
- Accept on edge E0. RUN edges are E1..EN. `out_valid` is high from the cycle after EN.
- Latency is N cycles from accept to `out_valid`; 4 cycles for WIDTH=16.
- Output handshake on edge Ed returns to IDLE; `in_ready` is high in the following cycle.
- Throughput with `out_ready` tied high: one operation per N+2 cycles.
- Critical path: one 4-bit CLA slice plus register setup. No WIDTH-length ripple path.

## Configuration
- `CLA_SUB_OVF_EN` defined:
  - Sign bits of `a` and `b` are latched at accept.
  - `ovf` is computed and registered as specified.
- Not defined:
  - `ovf` is tied to constant 0.
  - No sign-bit registers or overflow logic are instantiated.
  - The port remains present.

## Structure
- Package `cla_pkg` holds:
  - `localparam SLICE_W = 4`.
  - The state enum typedef `{IDLE, RUN, DONE}`.
  - The slice index width function `$clog2` of N, with a minimum of 1.
- Sub-module `cla4_slice`: combinational 4-bit CLA.
  - Inputs: `x[3:0]`, `y[3:0]`, `ci`.
  - Outputs: `s[3:0]`, `co`.
  - Carries are built from explicit generate/propagate terms.
  - Instantiated once, shared across slices.

## Test plan
- Basic subtract: WIDTH=16, `a=0x1234`, `b=0x0234`, `bin=0`, accept at E0 -> `out_valid` high after E4, `diff=0x1000`, `bout=0`, `ovf=0`.
- Unsigned underflow: `a=0x0000`, `b=0x0001` -> `diff=0xFFFF`, `bout=1`, `ovf=0`.
- Signed overflow: `a=0x8000`, `b=0x0001` -> `diff=0x7FFF`, `bout=0`; `ovf=1` with `CLA_SUB_OVF_EN` defined, `ovf=0` without it.
- Borrow in: `a=0x0005`, `b=0x0005`, `bin=1` -> `diff=0xFFFF`, `bout=1`.
- Backpressure: `out_ready` held low for 10 cycles in DONE with `in_valid` high and new operands -> `out_valid`, `diff` and `bout` stable, `in_ready=0`, no accept. After `out_ready`, the next operation completes with the new operands.
- Reset mid-run: `rst_n` low for one edge at k=2 -> `out_valid=0` and state IDLE after that edge. The following operation `0x00FF - 0x0001` yields `0x00FE`.
